// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address sizing, packed-port
// slicing and a population count used by the scoreboard.
package regfile_pkg;

  // Upper bound on register count handled by popcount(); callers zero-extend.
  localparam int MaxRegs = 1024;

  function automatic int addr_width(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  function automatic int unsigned popcount(input logic [MaxRegs-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxRegs; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for hazard detection: set on reservation, cleared on
// writeback, plus a registered WAW error pulse and a registered pending count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NumRegs       = 16,
  parameter  int NumWritePorts = 1,
  parameter  int ZeroReg       = 0,
  localparam int AddrWidth     = addr_width(NumRegs)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumWritePorts-1:0]           wr_en,
  input  logic [NumWritePorts*AddrWidth-1:0] wr_addr,
  input  logic                               rsv_en,
  input  logic [AddrWidth-1:0]               rsv_addr,
  output logic [NumRegs-1:0]                 pending,
  output logic                               rsv_err,
  output logic [AddrWidth:0]                 pending_cnt
);

  localparam int CntWidth = AddrWidth + 1;

  logic [NumRegs-1:0] wr_clr;
  logic [NumRegs-1:0] pend_nxt;
  logic               err_nxt;
  logic [MaxRegs-1:0] pend_ext;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_clr   = '0;
    pend_ext = '0;
    for (int k = 0; k < NumWritePorts; k++) begin
      if (wr_en[k]) wr_clr[wr_addr[slice_lo(k, AddrWidth) +: AddrWidth]] = 1'b1;
    end
    // A reservation dominates a same-cycle writeback to the same register.
    pend_nxt = pending & ~wr_clr;
    if (rsv_en) pend_nxt[rsv_addr] = 1'b1;
    if (ZeroReg != 0) pend_nxt[0] = 1'b0;
    err_nxt = rsv_en && pending[rsv_addr] && !wr_clr[rsv_addr] &&
              !(ZeroReg != 0 && rsv_addr == '0);
    pend_ext[NumRegs-1:0] = pend_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      rsv_err     <= 1'b0;
      pending_cnt <= '0;
    end else begin
      pending     <= pend_nxt;
      rsv_err     <= err_nxt;
      pending_cnt <= CntWidth'(popcount(pend_ext));
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with optional hardwired zero register, optional
// write-to-read bypass, and an integrated reservation scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter  int DataWidth     = 16,
  parameter  int NumRegs       = 16,
  parameter  int NumReadPorts  = 2,
  parameter  int NumWritePorts = 1,
  parameter  int ZeroReg       = 0,
  parameter  int Bypass        = 1,
  localparam int AddrWidth     = addr_width(NumRegs)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NumReadPorts*AddrWidth-1:0]  rd_addr,
  output logic [NumReadPorts*DataWidth-1:0]  rd_data,
  output logic [NumReadPorts-1:0]            rd_busy,
  input  logic [NumWritePorts-1:0]           wr_en,
  input  logic [NumWritePorts*AddrWidth-1:0] wr_addr,
  input  logic [NumWritePorts*DataWidth-1:0] wr_data,
  input  logic                               rsv_en,
  input  logic [AddrWidth-1:0]               rsv_addr,
  output logic                               rsv_err,
  output logic [NumRegs-1:0]                 pending,
  output logic [AddrWidth:0]                 pending_cnt
);

  logic [DataWidth-1:0] regs [NumRegs];

  // NOTE: the array is reset explicitly because software relies on a clean
  // architectural state; this costs a reset net per storage flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NumRegs; r++) regs[r] <= '0;
    end else begin
      // Ports are visited in ascending order so the highest index wins a tie.
      for (int k = 0; k < NumWritePorts; k++) begin
        if (wr_en[k] && !(ZeroReg != 0 && wr_addr[slice_lo(k, AddrWidth) +: AddrWidth] == '0)) begin
          regs[wr_addr[slice_lo(k, AddrWidth) +: AddrWidth]] <=
            wr_data[slice_lo(k, DataWidth) +: DataWidth];
        end
      end
    end
  end

  logic [AddrWidth-1:0] rd_a;
  logic [DataWidth-1:0] rd_d;
  logic                 rd_hit;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_a    = '0;
    rd_d    = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NumReadPorts; i++) begin
      rd_a   = rd_addr[slice_lo(i, AddrWidth) +: AddrWidth];
      rd_d   = regs[rd_a];
      rd_hit = 1'b0;
      if (Bypass != 0) begin
        for (int k = 0; k < NumWritePorts; k++) begin
          if (wr_en[k] && wr_addr[slice_lo(k, AddrWidth) +: AddrWidth] == rd_a) begin
            rd_d   = wr_data[slice_lo(k, DataWidth) +: DataWidth];
            rd_hit = 1'b1;
          end
        end
      end
      if (ZeroReg != 0 && rd_a == '0) rd_d = '0;
      rd_data[slice_lo(i, DataWidth) +: DataWidth] = rd_d;
      // Forwarded data resolves the hazard in the same cycle.
      rd_busy[i] = pending[rd_a] && !rd_hit;
    end
  end

  regfile_scoreboard #(
    .NumRegs      (NumRegs),
    .NumWritePorts(NumWritePorts),
    .ZeroReg      (ZeroReg)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .pending    (pending),
    .rsv_err    (rsv_err),
    .pending_cnt(pending_cnt)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: two builds (bypass/no-zero and no-bypass/zero-reg)
// share stimulus; a directed table, a reset sequence and random cycles are checked.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [3:0]  rsv_addr;
  logic [7:0]  rd_addr;

  logic [31:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic        rsv_err_a, rsv_err_b;
  logic [15:0] pending_a, pending_b;
  logic [4:0]  cnt_a, cnt_b;

  always #5 clk = ~clk;

  register_file_mp #(.NumWritePorts(2), .ZeroReg(0), .Bypass(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_err(rsv_err_a), .pending(pending_a), .pending_cnt(cnt_a)
  );

  register_file_mp #(.NumWritePorts(2), .ZeroReg(1), .Bypass(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_err(rsv_err_b), .pending(pending_b), .pending_cnt(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model; index 0 = build A (bypass, no zero reg), 1 = build B.
  logic [15:0] m_mem [2][16];
  logic [15:0] m_pend [2];
  logic        m_err [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 16; r++) m_mem[c][r] = '0;
      m_pend[c] = '0;
      m_err[c]  = 1'b0;
    end
  endtask

  task automatic model_compare(input int c);
    bit          zr, bp;
    int          win;
    logic [3:0]  a;
    logic [15:0] exp_d;
    logic        exp_b;
    logic [31:0] act_rd;
    logic [1:0]  act_busy;
    zr = (c == 1);
    bp = (c == 0);
    act_rd   = (c == 0) ? rd_data_a : rd_data_b;
    act_busy = (c == 0) ? rd_busy_a : rd_busy_b;
    for (int i = 0; i < 2; i++) begin
      a   = rd_addr[i*4 +: 4];
      win = -1;
      for (int k = 0; k < 2; k++) if (wr_en[k] && wr_addr[k*4 +: 4] == a) win = k;
      if (zr && a == 0)          exp_d = '0;
      else if (bp && win >= 0)   exp_d = wr_data[win*16 +: 16];
      else                       exp_d = m_mem[c][a];
      exp_b = (bp && win >= 0) ? 1'b0 : m_pend[c][a];
      check($sformatf("cfg%0d rd_data[%0d]", c, i), 32'(act_rd[i*16 +: 16]), 32'(exp_d));
      check($sformatf("cfg%0d rd_busy[%0d]", c, i), 32'(act_busy[i]), 32'(exp_b));
    end
    check($sformatf("cfg%0d pending", c), 32'((c == 0) ? pending_a : pending_b), 32'(m_pend[c]));
    check($sformatf("cfg%0d pending_cnt", c), 32'((c == 0) ? cnt_a : cnt_b), 32'($countones(m_pend[c])));
    check($sformatf("cfg%0d rsv_err", c), 32'((c == 0) ? rsv_err_a : rsv_err_b), 32'(m_err[c]));
  endtask

  // Called just after the edge while the inputs are still held.
  task automatic model_advance(input int c);
    bit          zr;
    logic [15:0] clr;
    zr  = (c == 1);
    clr = '0;
    for (int k = 0; k < 2; k++) if (wr_en[k]) clr[wr_addr[k*4 +: 4]] = 1'b1;
    m_err[c]  = rsv_en && m_pend[c][rsv_addr] && !clr[rsv_addr] && !(zr && rsv_addr == 0);
    m_pend[c] = m_pend[c] & ~clr;
    if (rsv_en && !(zr && rsv_addr == 0)) m_pend[c][rsv_addr] = 1'b1;
    for (int k = 0; k < 2; k++)
      if (wr_en[k] && !(zr && wr_addr[k*4 +: 4] == 0)) m_mem[c][wr_addr[k*4 +: 4]] = wr_data[k*16 +: 16];
  endtask

  // Inputs are already driven (after a negedge): compare, clock, advance model.
  task automatic step();
    #1;
    model_compare(0);
    model_compare(1);
    @(posedge clk);
    #1;
    model_advance(0);
    model_advance(1);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
  endtask

  typedef struct packed {
    logic [1:0]  en;
    logic [3:0]  wa0;
    logic [15:0] wd0;
    logic [3:0]  wa1;
    logic [15:0] wd1;
    logic        rsv;
    logic [3:0]  rsa;
    logic [3:0]  ra1;
    logic [15:0] exp_rd1_a;
    logic [15:0] exp_rd1_b;
    logic        exp_busy1_a;
    logic [4:0]  exp_cnt_a;
    logic        exp_err_a;
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{2'd1, 4'd3, 16'h1234, 4'd0, 16'h0,    1'b0, 4'd0, 4'd3, 16'h1234, 16'h0000, 1'b0, 5'd0, 1'b0};
    vecs[1]  = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b0, 4'd0, 4'd3, 16'h1234, 16'h1234, 1'b0, 5'd0, 1'b0};
    vecs[2]  = '{2'd3, 4'd7, 16'h0001, 4'd7, 16'h0002, 1'b0, 4'd0, 4'd7, 16'h0002, 16'h0000, 1'b0, 5'd0, 1'b0};
    vecs[3]  = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b0, 4'd0, 4'd7, 16'h0002, 16'h0002, 1'b0, 5'd0, 1'b0};
    vecs[4]  = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b1, 4'd4, 4'd4, 16'h0000, 16'h0000, 1'b0, 5'd0, 1'b0};
    vecs[5]  = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b0, 4'd0, 4'd4, 16'h0000, 16'h0000, 1'b1, 5'd1, 1'b0};
    vecs[6]  = '{2'd1, 4'd4, 16'h00AA, 4'd0, 16'h0,    1'b0, 4'd0, 4'd4, 16'h00AA, 16'h0000, 1'b0, 5'd1, 1'b0};
    vecs[7]  = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b0, 4'd0, 4'd4, 16'h00AA, 16'h00AA, 1'b0, 5'd0, 1'b0};
    vecs[8]  = '{2'd1, 4'd4, 16'h0055, 4'd0, 16'h0,    1'b1, 4'd4, 4'd4, 16'h0055, 16'h00AA, 1'b0, 5'd0, 1'b0};
    vecs[9]  = '{2'd1, 4'd4, 16'h0066, 4'd0, 16'h0,    1'b1, 4'd4, 4'd4, 16'h0066, 16'h0055, 1'b0, 5'd1, 1'b0};
    vecs[10] = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b1, 4'd6, 4'd4, 16'h0066, 16'h0066, 1'b1, 5'd1, 1'b0};
    vecs[11] = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b1, 4'd6, 4'd6, 16'h0000, 16'h0000, 1'b1, 5'd2, 1'b0};
    vecs[12] = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b0, 4'd0, 4'd6, 16'h0000, 16'h0000, 1'b1, 5'd2, 1'b1};
    vecs[13] = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b0, 4'd0, 4'd6, 16'h0000, 16'h0000, 1'b1, 5'd2, 1'b0};
    vecs[14] = '{2'd2, 4'd0, 16'h0,    4'd0, 16'hFFFF, 1'b0, 4'd0, 4'd0, 16'hFFFF, 16'h0000, 1'b0, 5'd2, 1'b0};
    vecs[15] = '{2'd0, 4'd0, 16'h0,    4'd0, 16'h0,    1'b0, 4'd0, 4'd0, 16'hFFFF, 16'h0000, 1'b0, 5'd2, 1'b0};

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state: every register reads zero on both ports.
    for (int r = 0; r < 16; r++) begin
      rd_addr = {4'(15 - r), 4'(r)};
      step();
    end
    check("reset pending_cnt A", 32'(cnt_a), 32'd0);

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      wr_en    = vecs[i].en;
      wr_addr  = {vecs[i].wa1, vecs[i].wa0};
      wr_data  = {vecs[i].wd1, vecs[i].wd0};
      rsv_en   = vecs[i].rsv;
      rsv_addr = vecs[i].rsa;
      rd_addr  = {vecs[i].ra1, 4'(i)};
      #1;
      check($sformatf("vec%0d rd_data[1] A", i), 32'(rd_data_a[31:16]), 32'(vecs[i].exp_rd1_a));
      check($sformatf("vec%0d rd_data[1] B", i), 32'(rd_data_b[31:16]), 32'(vecs[i].exp_rd1_b));
      check($sformatf("vec%0d rd_busy[1] A", i), 32'(rd_busy_a[1]), 32'(vecs[i].exp_busy1_a));
      check($sformatf("vec%0d pending_cnt A", i), 32'(cnt_a), 32'(vecs[i].exp_cnt_a));
      check($sformatf("vec%0d rsv_err A", i), 32'(rsv_err_a), 32'(vecs[i].exp_err_a));
      step();
    end

    // Reset asserted while a write of 0xBEEF to r5 is on the bus.
    idle_inputs();
    wr_en = 2'b01; wr_addr = 8'h05; wr_data = 32'h0000_BEEF; rsv_en = 1'b1; rsv_addr = 4'd9;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 model_reset();
    @(negedge clk);
    idle_inputs();
    rst_n   = 1'b1;
    rd_addr = 8'h55;
    #1;
    check("mid-reset r5 A", 32'(rd_data_a[15:0]), 32'h0);
    check("mid-reset r5 B", 32'(rd_data_b[31:16]), 32'h0);
    check("mid-reset pending A", 32'(pending_a), 32'h0);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = 8'($urandom);
      wr_data  = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 4'($urandom);
      rd_addr  = ($urandom_range(0, 3) == 0) ? {wr_addr[7:4], rsv_addr} : 8'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
